// File: rtl/tmds_channel_encoder_ctrl.sv
// rtl/tmds_channel_encoder_ctrl.sv - DVI TMDS channel encoder: 8->9 pre-encode, DC balancing, control tokens
// Two enabled-cycle pipeline: S1 registers the transition-minimised word, S2 picks the symbol and updates disparity.
module tmds_channel_encoder_ctrl #(
    parameter int         CNT_W     = 6,
    parameter logic [9:0] RST_TOKEN = 10'h354
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_de,
    input  logic [7:0]       i_data,
    input  logic [1:0]       i_ctrl,
    output logic [9:0]       o_tmds,
    output logic             o_de,
    output logic [CNT_W-1:0] o_disp
);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] EIGHT = CNT_W'(8);

    logic             s1_de_q, s1_de_d;
    logic [1:0]       s1_ctrl_q, s1_ctrl_d;
    logic [8:0]       s1_qm_q, s1_qm_d;
    logic [9:0]       tmds_q, tmds_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       n1_data;
    logic             use_xnor;
    logic [3:0]       n1q;
    logic [CNT_W-1:0] n1q_ext;
    logic [CNT_W-1:0] diff;
    logic             q8;
    logic             cnt_pos;
    logic             cnt_neg;

    // S1: XNOR chain when the byte is one-heavy, which minimises transitions in q_m
    always_comb begin
        n1_data = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_data = n1_data + {3'd0, i_data[i]};
        end
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !i_data[0]);
        s1_qm_d    = 9'd0;
        s1_qm_d[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            s1_qm_d[i] = use_xnor ? ~(s1_qm_d[i-1] ^ i_data[i]) : (s1_qm_d[i-1] ^ i_data[i]);
        end
        s1_qm_d[8] = ~use_xnor;
        s1_de_d    = i_de;
        s1_ctrl_d  = i_ctrl;
    end

    // S2: diff is N1q - N0q, i.e. 2*N1q - 8, in CNT_W-bit two's complement
    always_comb begin
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1q = n1q + {3'd0, s1_qm_q[i]};
        end
        n1q_ext = {{(CNT_W-4){1'b0}}, n1q};
        diff    = {n1q_ext[CNT_W-2:0], 1'b0} - EIGHT;
        q8      = s1_qm_q[8];
        cnt_neg = cnt_q[CNT_W-1];
        cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);

        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        de_d   = s1_de_q;
        if (!s1_de_q) begin
            cnt_d = '0;
            case (s1_ctrl_q)
                2'b00:   tmds_d = 10'h354;
                2'b01:   tmds_d = 10'h0AB;
                2'b10:   tmds_d = 10'h154;
                default: tmds_d = 10'h2AB;
            endcase
        end else if ((cnt_q == '0) || (n1q == 4'd4)) begin
            tmds_d = {~q8, q8, q8 ? s1_qm_q[7:0] : ~s1_qm_q[7:0]};
            cnt_d  = q8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
            tmds_d = {1'b1, q8, ~s1_qm_q[7:0]};
            cnt_d  = cnt_q + (q8 ? TWO : '0) - diff;
        end else begin
            tmds_d = {1'b0, q8, s1_qm_q[7:0]};
            cnt_d  = cnt_q + diff - (q8 ? '0 : TWO);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_de_q   <= 1'b0;
            s1_ctrl_q <= 2'b00;
            s1_qm_q   <= 9'd0;
            tmds_q    <= RST_TOKEN;
            de_q      <= 1'b0;
            cnt_q     <= '0;
        end else if (i_ce) begin
            s1_de_q   <= s1_de_d;
            s1_ctrl_q <= s1_ctrl_d;
            s1_qm_q   <= s1_qm_d;
            tmds_q    <= tmds_d;
            de_q      <= de_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_tmds = tmds_q;
    assign o_de   = de_q;
    assign o_disp = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder_ctrl.sv
// tb/tb_tmds_channel_encoder_ctrl.sv - self-checking bench for tmds_channel_encoder_ctrl
module tb_tmds_channel_encoder_ctrl;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce    = 1'b1;
    logic       de    = 1'b0;
    logic [7:0] data  = 8'd0;
    logic [1:0] ctrl  = 2'd0;
    logic [9:0] tmds;
    logic       o_de;
    logic [5:0] disp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmds_channel_encoder_ctrl #(.CNT_W(6), .RST_TOKEN(10'h354)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_ce   (ce),
        .i_de   (de),
        .i_data (data),
        .i_ctrl (ctrl),
        .o_tmds (tmds),
        .o_de   (o_de),
        .o_disp (disp)
    );

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [9:0] exp_tmds;
        logic       exp_de;
        int         exp_disp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    // reference pipeline state
    logic       m_s1_de;
    logic [8:0] m_s1_qm;
    logic [1:0] m_s1_ctrl;
    logic [7:0] m_s1_data;
    logic [9:0] m_tmds;
    logic       m_de;
    logic [7:0] m_data;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] pre_enc(input logic [7:0] d);
        int ones;
        logic xn;
        logic [8:0] q;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        return q;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    task automatic model_reset();
        m_s1_de = 1'b0; m_s1_qm = 9'd0; m_s1_ctrl = 2'd0; m_s1_data = 8'd0;
        m_tmds = 10'h354; m_de = 1'b0; m_data = 8'd0; m_cnt = 0;
    endtask

    task automatic model_s2();
        int n1;
        int n0;
        if (!m_s1_de) begin
            m_cnt = 0;
            case (m_s1_ctrl)
                2'd0: m_tmds = 10'h354;
                2'd1: m_tmds = 10'h0AB;
                2'd2: m_tmds = 10'h154;
                default: m_tmds = 10'h2AB;
            endcase
        end else begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(m_s1_qm[i]);
            n0 = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                if (m_s1_qm[8]) begin
                    m_tmds = {2'b01, m_s1_qm[7:0]};
                    m_cnt += n1 - n0;
                end else begin
                    m_tmds = {2'b10, ~m_s1_qm[7:0]};
                    m_cnt += n0 - n1;
                end
            end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
                m_tmds = {1'b1, m_s1_qm[8], ~m_s1_qm[7:0]};
                m_cnt += (m_s1_qm[8] ? 2 : 0) + n0 - n1;
            end else begin
                m_tmds = {1'b0, m_s1_qm[8], m_s1_qm[7:0]};
                m_cnt += n1 - n0 - (m_s1_qm[8] ? 0 : 2);
            end
        end
    endtask

    task automatic step(input logic c, input logic d, input logic [7:0] dt, input logic [1:0] ct);
        logic [5:0] mc;
        ce = c; de = d; data = dt; ctrl = ct;
        @(posedge clk);
        if (ce) begin
            model_s2();
            m_de = m_s1_de; m_data = m_s1_data;
            m_s1_de = de; m_s1_qm = pre_enc(data); m_s1_ctrl = ctrl; m_s1_data = data;
        end
        #1;
        mc = 6'(m_cnt);
        check("symbol_de_disp", {15'd0, o_de, disp, tmds}, {15'd0, m_de, mc, m_tmds});
        if (m_de) begin
            check("decoded_data", {24'd0, decode(tmds)}, {24'd0, m_data});
            check("disp_bound", {31'd0, ($signed(disp) <= 6'sd10) && ($signed(disp) >= -6'sd10)}, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tmds"}, {22'd0, tmds}, 32'h354);
        check({tag, "_de"}, {31'd0, o_de}, 32'd0);
        check({tag, "_disp"}, {26'd0, disp}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 2'd0, 10'h354, 1'b0,  0};
        vecs[1]  = '{1'b0, 8'h00, 2'd1, 10'h0AB, 1'b0,  0};
        vecs[2]  = '{1'b0, 8'h00, 2'd2, 10'h154, 1'b0,  0};
        vecs[3]  = '{1'b0, 8'h00, 2'd3, 10'h2AB, 1'b0,  0};
        vecs[4]  = '{1'b1, 8'h00, 2'd0, 10'h100, 1'b1, -8};
        vecs[5]  = '{1'b1, 8'h00, 2'd0, 10'h3FF, 1'b1,  2};
        vecs[6]  = '{1'b0, 8'h00, 2'd0, 10'h354, 1'b0,  0};
        vecs[7]  = '{1'b1, 8'hFF, 2'd0, 10'h200, 1'b1, -8};
        vecs[8]  = '{1'b0, 8'h00, 2'd1, 10'h0AB, 1'b0,  0};
        vecs[9]  = '{1'b1, 8'h10, 2'd0, 10'h1F0, 1'b1,  0};
        vecs[10] = '{1'b1, 8'h01, 2'd0, 10'h1FF, 1'b1,  8};
        vecs[11] = '{1'b1, 8'h01, 2'd0, 10'h300, 1'b1,  2};
        vecs[12] = '{1'b1, 8'h00, 2'd0, 10'h100, 1'b1, -6};
        vecs[13] = '{1'b1, 8'hFF, 2'd0, 10'h0FF, 1'b1,  0};
        vecs[14] = '{1'b0, 8'h00, 2'd2, 10'h154, 1'b0,  0};
        vecs[15] = '{1'b0, 8'h00, 2'd0, 10'h354, 1'b0,  0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // hand-computed vectors; output for vector i appears after the edge that loads vector i+1
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) step(1'b1, vecs[i].de, vecs[i].data, vecs[i].ctrl);
            else        step(1'b1, 1'b0, 8'h00, 2'd0);
            if (i >= 1) begin
                check("vec_tmds", {22'd0, tmds}, {22'd0, vecs[i-1].exp_tmds});
                check("vec_de", {31'd0, o_de}, {31'd0, vecs[i-1].exp_de});
                check("vec_disp", 32'(int'($signed(disp))), 32'(vecs[i-1].exp_disp));
            end
        end

        // clock-enable stalls: random ce, each pixel held until accepted
        for (int p = 0; p < 64; p++) begin
            logic [7:0] px;
            logic       acc;
            px  = 8'($urandom_range(0, 255));
            acc = 1'b0;
            for (int t = 0; t < 16 && !acc; t++) begin
                acc = (t == 15) ? 1'b1 : 1'($urandom_range(0, 1));
                step(acc, 1'b1, px, 2'd0);
            end
        end
        for (int k = 0; k < 4; k++) step(1'($urandom_range(0, 1)), 1'b0, 8'h00, 2'(k));
        step(1'b1, 1'b0, 8'h00, 2'd0);
        step(1'b1, 1'b0, 8'h00, 2'd0);

        // reset in the middle of a line
        for (int p = 0; p < 5; p++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 2'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1, 8'h00, 2'd0);
        check("post_reset_first_token", {22'd0, tmds}, 32'h354);
        step(1'b1, 1'b1, 8'h00, 2'd0);
        check("post_reset_first_pixel", {22'd0, tmds}, 32'h100);

        // long random lines with blanking between them
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 40; p++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 2'd0);
            for (int b = 0; b < 4; b++) step(1'b1, 1'b0, 8'h00, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
